// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
//
// Shared definitions for the nibble-serial adder sequencer and its arithmetic
// slice:
//   NIBBLE_W   - width of one arithmetic slice (one nibble)
//   state_t    - sequencer state encoding (IDLE / RUN / DONE, 2 bits)
//   signed_ovf - two's-complement overflow rule for a + b (+ cin)
// -----------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Overflow occurs only when both operands share a sign and the result's
  // sign differs from it. A carry-in cannot change this rule, because a
  // carry-in alone cannot push the result across a sign boundary.
  function automatic logic signed_ovf(input logic sign_a,
                                      input logic sign_b,
                                      input logic sum_msb);
    return (sign_a == sign_b) && (sum_msb != sign_a);
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// -----------------------------------------------------------------------------
// four_bit_adder
//
// Combinational 4-bit adder slice with carry in and carry out. This is the
// single arithmetic element that the nibble-serial sequencer time-multiplexes.
//
// Ports:
//   A    in  [3:0]  addend
//   B    in  [3:0]  addend
//   Cin  in         carry in
//   Sum  out [3:0]  (A + B + Cin) mod 16
//   Cout out        carry out of bit 3
// -----------------------------------------------------------------------------
module four_bit_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] Sum,
  output logic                Cout
);

  // One extra bit captures the carry out of the slice.
  logic [NIBBLE_W:0] total;

  assign total = {1'b0, A} + {1'b0, B} + {{NIBBLE_W{1'b0}}, Cin};
  assign Sum   = total[NIBBLE_W-1:0];
  assign Cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Performs a WIDTH-bit addition a + b + cin by running one four_bit_adder
// slice for NIBBLES = WIDTH/4 clocks, least significant nibble first. The
// inter-nibble carry lives in a register, and sum nibbles are collected in a
// shift register. This trades latency for area compared with a full-width
// ripple adder.
//
// Handshake: start is sampled only in IDLE. The accepting edge latches a, b
// and cin. busy covers RUN and DONE. done pulses for one cycle, and at that
// point sum/cout/overflow are valid. They stay held until the next accepted
// operation completes.
//
// Parameters:
//   WIDTH     operand/sum width; must be a multiple of 4 and at least 8
//
// Ports:
//   clk       in             rising-edge clock
//   rst       in             synchronous active-high reset
//   start     in             request; sampled only in IDLE
//   a         in  [WIDTH-1]  operand A; sampled on the accepting edge only
//   b         in  [WIDTH-1]  operand B; sampled on the accepting edge only
//   cin       in             carry in; sampled on the accepting edge only
//   busy      out            high in RUN and DONE
//   done      out            one-cycle pulse: result valid
//   sum       out [WIDTH-1]  (a + b + cin) mod 2^WIDTH
//   cout      out            carry out of bit WIDTH-1
//   overflow  out            two's-complement overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  // Holds 0 .. NIBBLES-1. The terminal compare fires before the counter
  // would need to wrap.
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]          a_sh;      // operand A, consumed a nibble at a time
  logic [WIDTH-1:0]          b_sh;      // operand B, consumed a nibble at a time
  logic [WIDTH-NIBBLE_W-1:0] sum_sh;    // nibbles produced so far (top-aligned)
  logic                      carry_r;   // carry between nibbles
  logic [CNT_W-1:0]          cnt;       // index of the nibble being processed
  logic                      sa;        // sign of A at acceptance
  logic                      sb;        // sign of B at acceptance

  logic [NIBBLE_W-1:0]       slice_sum;
  logic                      slice_cout;
  logic [WIDTH-1:0]          sum_next;  // shift-register contents after this RUN edge
  logic                      accept;
  logic                      last_nib;

  // ---------------------------------------------------------------------------
  // Arithmetic slice: always looks at the low nibble of the operand shifters.
  // ---------------------------------------------------------------------------
  four_bit_adder u_slice (
    .A    (a_sh[NIBBLE_W-1:0]),
    .B    (b_sh[NIBBLE_W-1:0]),
    .Cin  (carry_r),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // The new nibble enters at the top and earlier nibbles move right. After
  // the last nibble, this word is the complete little-endian-ordered result.
  assign sum_next = {slice_sum, sum_sh};

  assign accept   = (state == ST_IDLE) && start;
  assign last_nib = (state == ST_RUN) && (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred when a branch does not assign state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)           state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE:                      state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry, counter, sign latches, result.
  // Reset clears everything, including the visible result, so an operation
  // aborted by reset leaves no partial result behind.
  // ---------------------------------------------------------------------------
  // NOTE: these are discrete flops rather than a memory array, so each one
  // can be given a synchronous reset value without cost or inference issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry_r  <= 1'b0;
      cnt      <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_r <= cin;
      cnt     <= '0;
      sa      <= a[WIDTH-1];
      sb      <= b[WIDTH-1];
    end else if (state == ST_RUN) begin
      a_sh    <= a_sh >> NIBBLE_W;
      b_sh    <= b_sh >> NIBBLE_W;
      sum_sh  <= sum_next[WIDTH-1:NIBBLE_W];
      carry_r <= slice_cout;
      cnt     <= cnt + 1'b1;
      if (last_nib) begin
        sum      <= sum_next;
        cout     <= slice_cout;
        overflow <= signed_ovf(sa, sb, sum_next[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int NIB16 = 4;
  localparam int NIB8  = 2;

  logic clk = 1'b0;
  logic rst;

  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  // Reference: plain integer arithmetic on the full-width values.
  task automatic ref_add(input int w, input longint ua, input longint ub, input bit ucin,
                         output longint es, output bit ecout, output bit eovf);
    longint full, modv, half, sa, sb, ss;
    modv  = longint'(1) << w;
    half  = modv / 2;
    full  = ua + ub + longint'(ucin);
    es    = full % modv;
    ecout = (full >= modv);
    sa    = (ua >= half) ? ua - modv : ua;
    sb    = (ub >= half) ? ub - modv : ub;
    ss    = sa + sb + longint'(ucin);
    eovf  = (ss >= half) || (ss < -half);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 16-bit operation. Inputs are scrambled and start is toggled while busy
  // to confirm they are ignored.
  task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                          input string tag);
    longint es; bit ec, eo;
    int n, busy_cycles, extra_done;
    bit seen;
    ref_add(16, longint'(ta), longint'(tb), tcin, es, ec, eo);
    a16 = ta; b16 = tb; cin16 = tcin; start16 = 1'b1;
    tick();
    total++;
    if (busy16 !== 1'b1 || done16 !== 1'b0) begin
      bad++; $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", tag, busy16, done16);
    end
    busy_cycles = 1; n = 0; seen = 0;
    while (!seen && n < 12) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); start16 = 1'($urandom);
      tick();
      n++;
      if (busy16) busy_cycles++;
      if (done16) seen = 1;
    end
    start16 = 1'b0;
    total++;
    if (!seen || n != NIB16) begin
      bad++; $display("FAIL %s latency: edges=%0d seen=%0d want %0d", tag, n, seen, NIB16);
    end
    total++;
    if (busy_cycles != NIB16 + 1) begin
      bad++; $display("FAIL %s busy_len: got %0d want %0d", tag, busy_cycles, NIB16 + 1);
    end
    total++;
    if (sum16 !== 16'(es)) begin
      bad++; $display("FAIL %s sum: got %h want %h", tag, sum16, 16'(es));
    end
    total++;
    if (cout16 !== ec) begin
      bad++; $display("FAIL %s cout: got %b want %b", tag, cout16, ec);
    end
    total++;
    if (ovf16 !== eo) begin
      bad++; $display("FAIL %s overflow: got %b want %b", tag, ovf16, eo);
    end
    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done16 || busy16 || sum16 !== 16'(es)) extra_done++;
    end
    total++;
    if (extra_done != 0) begin
      bad++; $display("FAIL %s hold: %0d idle cycles with done/busy or changed sum (sum=%h want %h)",
                      tag, extra_done, sum16, 16'(es));
    end
  endtask

  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                         input string tag);
    longint es; bit ec, eo;
    int n;
    bit seen;
    ref_add(8, longint'(ta), longint'(tb), tcin, es, ec, eo);
    a8 = ta; b8 = tb; cin8 = tcin; start8 = 1'b1;
    tick();
    n = 0; seen = 0;
    while (!seen && n < 8) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
      tick();
      n++;
      if (done8) seen = 1;
    end
    start8 = 1'b0;
    total++;
    if (!seen || n != NIB8) begin
      bad++; $display("FAIL %s latency: edges=%0d seen=%0d want %0d", tag, n, seen, NIB8);
    end
    total++;
    if (sum8 !== 8'(es) || cout8 !== ec || ovf8 !== eo) begin
      bad++; $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                      tag, sum8, cout8, ovf8, 8'(es), ec, eo);
    end
    tick();
    total++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++; $display("FAIL %s return_idle: done=%b busy=%b want 0 0", tag, done8, busy8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    tick(); tick();
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin
      bad++; $display("FAIL reset16 ctl: busy=%b done=%b want 0 0", busy16, done16);
    end
    total++;
    if (sum16 !== 16'h0 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      bad++; $display("FAIL reset16 result: sum=%h cout=%b ovf=%b want 0", sum16, cout16, ovf16);
    end
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h0 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      bad++; $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                      busy8, done8, sum8, cout8, ovf8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed16();
    run_op16(16'h0000, 16'h0000, 1'b0, "zero");
    run_op16(16'hFFFF, 16'h0001, 1'b0, "ripple_all");
    run_op16(16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
    run_op16(16'h8000, 16'h8000, 1'b0, "neg_ovf");
    run_op16(16'h1234, 16'h4321, 1'b1, "mixed_cin");
  endtask

  task automatic test_abort();
    int stray;
    a16 = 16'hABCD; b16 = 16'h1111; cin16 = 1'b1; start16 = 1'b1;
    tick();               // accepting edge
    start16 = 1'b0;
    tick();               // first RUN edge
    rst = 1'b1;
    tick();               // second RUN edge with reset
    rst = 1'b0;
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || sum16 !== 16'h0 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      bad++; $display("FAIL abort: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                      busy16, done16, sum16, cout16, ovf16);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done16 || busy16) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL abort_quiet: %0d cycles with busy/done after abort, want 0", stray);
    end
    run_op16(16'h00FF, 16'h0001, 1'b0, "abort_fresh");
  endtask

  task automatic test_back_to_back16();
    int idx[$];
    int bad_sum, drain;
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
    bad_sum = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done16) begin
        idx.push_back(i);
        if (sum16 !== 16'h0002 || cout16 !== 1'b0 || ovf16 !== 1'b0) bad_sum++;
      end
    end
    start16 = 1'b0;
    total++;
    if (idx.size() != (20 - (NIB16 + 1)) / (NIB16 + 2) + 1) begin
      bad++; $display("FAIL b2b16 count: got %0d dones want %0d", idx.size(),
                      (20 - (NIB16 + 1)) / (NIB16 + 2) + 1);
    end
    total++;
    if (idx.size() == 0 || idx[0] != NIB16 + 1) begin
      bad++; $display("FAIL b2b16 first: got edge %0d want %0d",
                      (idx.size() == 0) ? -1 : idx[0], NIB16 + 1);
    end
    for (int k = 1; k < idx.size(); k++) begin
      total++;
      if (idx[k] - idx[k-1] != NIB16 + 2) begin
        bad++; $display("FAIL b2b16 spacing: got %0d want %0d", idx[k] - idx[k-1], NIB16 + 2);
      end
    end
    total++;
    if (bad_sum != 0) begin
      bad++; $display("FAIL b2b16 result: %0d dones with wrong result, want 0", bad_sum);
    end
    drain = 0;
    while (busy16 && drain < 2 * NIB16 + 4) begin
      tick();
      drain++;
    end
    total++;
    if (busy16 !== 1'b0) begin
      bad++; $display("FAIL b2b16 drain: busy=%b want 0", busy16);
    end
  endtask

  task automatic test_width8();
    int idx[$];
    int bad_sum, drain;
    run_op8(8'hFF, 8'hFF, 1'b1, "w8_ff_ff_cin");
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    bad_sum = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done8) begin
        idx.push_back(i);
        if (sum8 !== 8'hFF || cout8 !== 1'b1 || ovf8 !== 1'b0) bad_sum++;
      end
    end
    start8 = 1'b0;
    total++;
    if (idx.size() != 3 || idx[0] != NIB8 + 1 || idx[1] - idx[0] != NIB8 + 2 || idx[2] - idx[1] != NIB8 + 2) begin
      bad++; $display("FAIL b2b8 timing: %0d dones, first at %0d, want 3 starting at %0d every %0d",
                      idx.size(), (idx.size() == 0) ? -1 : idx[0], NIB8 + 1, NIB8 + 2);
    end
    total++;
    if (bad_sum != 0) begin
      bad++; $display("FAIL b2b8 result: %0d dones with wrong result, want 0", bad_sum);
    end
    drain = 0;
    while (busy8 && drain < 10) begin
      tick();
      drain++;
    end
    total++;
    if (busy8 !== 1'b0) begin
      bad++; $display("FAIL b2b8 drain: busy=%b want 0", busy8);
    end
    for (int i = 0; i < 12; i++) run_op8(8'($urandom), 8'($urandom), 1'($urandom), "w8_rand");
  endtask

  task automatic test_random16();
    for (int i = 0; i < 25; i++) run_op16(16'($urandom), 16'($urandom), 1'($urandom), "rand16");
  endtask

  initial begin
    test_reset();
    test_directed16();
    test_abort();
    test_back_to_back16();
    test_random16();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
